histogram_scanner: RTL and testbench
====================================

Name: histogram_scanner

Overview:
- Controller and readout stage wrapped around histogram_unit. It owns the unit's d_in, ENA and RST inputs and consumes its mem_out.
- Three modes:
  - Accumulate: pass samples through to the unit.
  - Clear: wipe the bin memory.
  - Scan: sweep every bin and stream the (bin, count) pairs, then report peak bin, peak count and total sample count.

Parameters:
- MAX_NUMBER, 127: largest sample value. AW = $clog2(MAX_NUMBER), which is the address width.
- SIZE, 7: bin counter width. Must match histogram_unit.
- RD_LAT, 2: CLK cycles from d_in presented to matching mem_out valid. Range 1..4.
- CLR_CYCLES, 1 << AW: cycles hist_clr is held high to sweep all addresses.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- sample_valid  in  1  a sample is present this cycle.
- sample_data  in  AW  sample value.
- clear_req  in  1  one-cycle pulse: start a clear.
- scan_req  in  1  one-cycle pulse: start a scan.
- d_in  out  AW  to histogram_unit d_in.
- ena  out  1  to histogram_unit ENA.
- hist_clr  out  1  to histogram_unit RST.
- mem_out  in  SIZE  from histogram_unit mem_out.
- busy  out  1  high in any state except IDLE.
- out_valid  out  1  out_bin/out_count valid this cycle.
- out_bin  out  AW  bin index.
- out_count  out  SIZE  bin count.
- done  out  1  one-cycle pulse at end of a scan.
- peak_bin  out  AW  bin with the largest count.
- peak_count  out  SIZE  that bin's count.
- total_count  out  SIZE+AW  sum of all bin counts.

Behaviour:
- Reset (RST_N low, async):
  - State = IDLE.
  - All outputs 0: d_in, ena, hist_clr, busy, out_valid, out_bin, out_count, done, peak_bin, peak_count, total_count.
  - Internal counters 0.
- Clock/reset: one clock domain, CLK. Reset asserts asynchronously and is released synchronously to CLK.
- IDLE (accumulate mode):
  - d_in and ena are registered copies of sample_data and sample_valid: one cycle latency, ena = sample_valid delayed by 1.
  - clear_req → CLEAR.
  - scan_req → SCAN.
  - Both in the same cycle: CLEAR wins and the scan request is dropped.
  - Samples arriving in the transition cycle are dropped; ena is 0 from the cycle after the request.
- CLEAR:
  - hist_clr = 1, ena = 0 for exactly CLR_CYCLES cycles, then → IDLE.
  - Requests received while in CLEAR are ignored.
- SCAN:
  - Issues addresses 0, 1, …, (1<<AW)-1 on d_in, one per cycle, with ena = 0.
  - An RD_LAT-deep shift register carries the address and an issue flag alongside the memory read.
  - After the last address is issued → DRAIN.
- DRAIN:
  - Waits RD_LAT cycles for the remaining reads to return, then → DONE.
- Output stream (SCAN and DRAIN):
  - When a delayed issue flag emerges: out_valid = 1, out_bin = delayed address, out_count = mem_out.
  - Exactly 1<<AW beats in increasing bin order, contiguous, no backpressure.
- Peak tracking:
  - Running peak cleared on entry to SCAN.
  - Update only when count is strictly greater than the current peak, so the lowest bin index wins ties.
  - All-zero histogram → peak_bin = 0, peak_count = 0.
- total_count:
  - Cleared on entry to SCAN and accumulates each beat.
  - Width SIZE+AW, so it cannot overflow.
- DONE:
  - done = 1 for one cycle, then → IDLE.
  - peak_bin, peak_count and total_count hold their values until the next scan starts.
- Requests while busy: clear_req and scan_req are ignored (not queued).
- Reset mid-scan or mid-clear: returns to IDLE immediately and no done is issued. Memory content is undefined after a reset mid-clear, so a new clear is required.

Optional Feature:
- Macro: HIST_SCAN_THRESH_EN.
- When defined:
  - Adds input thresh [SIZE-1:0] and output above_cnt [AW:0].
  - out_valid asserts only for bins with count ≥ thresh.
  - above_cnt counts those bins; it resets to 0 and is cleared on entry to SCAN.
  - Peak and total still cover all bins.
- When not defined: neither port exists and every bin is streamed.

Decomposition:
- Package hist_pkg holds:
  - function/localparam for AW derived from MAX_NUMBER;
  - enum scan_state_t {IDLE, CLEAR, SCAN, DRAIN, DONE};
  - default SIZE and RD_LAT constants.
- Sub-module hist_peak_tracker:
  - inputs: valid, bin, count, start;
  - outputs: peak_bin, peak_count, total_count;
  - implements the strict-greater update and total accumulation.
- Top level holds the FSM, address counter, clear counter and latency shift register.

Test Plan:
1. Reset mid-SCAN (RST_N low at beat 10) → all outputs 0 asynchronously; state IDLE; no done; busy=0 after release.
2. clear_req, then scan with no samples → hist_clr high exactly 128 cycles; scan streams 128 beats all count 0; peak_bin=0, peak_count=0, total_count=0, done one cycle.
3. Samples 5,5,5,9,9,127 (sample_valid=1) then scan_req → out_count[5]=3, [9]=2, [127]=1, others 0; peak_bin=5, peak_count=3, total_count=6.
4. Tie: bins 3 and 40 both count 4 → peak_bin=3.
5. clear_req and scan_req in the same cycle → CLEAR only, no stream; scan_req during SCAN → ignored, exactly 128 beats, one done.
6. With HIST_SCAN_THRESH_EN and thresh=2 on the data from scenario 3 → beats only for bins 5 and 9, above_cnt=2, total_count=6.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram scanner: address width helper,
// controller state encoding and default bin/latency parameters.
package hist_pkg;

   localparam int MAX_NUMBER_DEF = 127;
   localparam int SIZE_DEF       = 7;
   localparam int RD_LAT_DEF     = 2;

   // Address width needed to index bins 0..max_number.
   function automatic int addr_width(input int max_number);
      return (max_number < 2) ? 1 : $clog2(max_number);
   endfunction

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SCAN  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

endpackage

// File: rtl/hist_peak_tracker.sv
// Running peak (strictly-greater update, lowest bin wins ties) and total sum
// over the scan output beats; cleared by a start pulse.
module hist_peak_tracker #(
   parameter int AW   = 7,
   parameter int SIZE = 7
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 start,
   input  logic                 valid,
   input  logic [AW-1:0]        bin,
   input  logic [SIZE-1:0]      count,
   output logic [AW-1:0]        peak_bin,
   output logic [SIZE-1:0]      peak_count,
   output logic [SIZE+AW-1:0]   total_count
);

   logic [AW-1:0]      peak_bin_q, peak_bin_d;
   logic [SIZE-1:0]    peak_count_q, peak_count_d;
   logic [SIZE+AW-1:0] total_q, total_d;

   always_comb begin
      peak_bin_d   = peak_bin_q;
      peak_count_d = peak_count_q;
      total_d      = total_q;
      if (start) begin
         peak_bin_d   = '0;
         peak_count_d = '0;
         total_d      = '0;
      end else if (valid) begin
         total_d = total_q + (SIZE+AW)'(count);
         if (count > peak_count_q) begin
            peak_bin_d   = bin;
            peak_count_d = count;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         peak_bin_q   <= '0;
         peak_count_q <= '0;
         total_q      <= '0;
      end else begin
         peak_bin_q   <= peak_bin_d;
         peak_count_q <= peak_count_d;
         total_q      <= total_d;
      end
   end

   assign peak_bin    = peak_bin_q;
   assign peak_count  = peak_count_q;
   assign total_count = total_q;

endmodule

// File: rtl/histogram_scanner.sv
// Controller/readout around histogram_unit: accumulate, clear sweep and bin scan.
// Optional per-bin threshold filter on the output stream: HIST_SCAN_THRESH_EN.
module histogram_scanner
   import hist_pkg::*;
#(
   parameter int MAX_NUMBER = MAX_NUMBER_DEF,
   parameter int SIZE       = SIZE_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int CLR_CYCLES = 1 << addr_width(MAX_NUMBER),
   localparam int AW        = addr_width(MAX_NUMBER)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 sample_valid,
   input  logic [AW-1:0]        sample_data,
   input  logic                 clear_req,
   input  logic                 scan_req,
`ifdef HIST_SCAN_THRESH_EN
   input  logic [SIZE-1:0]      thresh,
   output logic [AW:0]          above_cnt,
`endif
   output logic [AW-1:0]        d_in,
   output logic                 ena,
   output logic                 hist_clr,
   input  logic [SIZE-1:0]      mem_out,
   output logic                 busy,
   output logic                 out_valid,
   output logic [AW-1:0]        out_bin,
   output logic [SIZE-1:0]      out_count,
   output logic                 done,
   output logic [AW-1:0]        peak_bin,
   output logic [SIZE-1:0]      peak_count,
   output logic [SIZE+AW-1:0]   total_count
);

   localparam int CW = $clog2(CLR_CYCLES) + 1;
   localparam logic [AW-1:0] LAST_ADDR = '1;

   scan_state_t       state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
   logic [AW-1:0]     d_in_q, d_in_d;
   logic              ena_q, ena_d;
   logic              hist_clr_q, hist_clr_d;
   logic              issue_q, issue_d;
   logic [RD_LAT-1:0] pipe_vld_q;
   logic [AW-1:0]     pipe_bin_q [RD_LAT];
   logic              beat;
   logic [AW-1:0]     beat_bin;
   logic              pass;
   logic              scan_start;

   // State and sweep counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // DRAIN ends on the beat carrying the last address, so DONE follows the final beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clear_req) state_d = CLEAR;
                  else if (scan_req) state_d = SCAN;
         CLEAR:   if (clr_cnt_q == CW'(CLR_CYCLES - 1)) state_d = IDLE;
         SCAN:    if (addr_q == LAST_ADDR) state_d = DRAIN;
         DRAIN:   if (beat && (beat_bin == LAST_ADDR)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Unit-side drive; registered, so it lags the issuing state by one cycle.
   always_comb begin
      d_in_d     = d_in_q;
      ena_d      = 1'b0;
      hist_clr_d = 1'b0;
      issue_d    = 1'b0;
      addr_d     = addr_q;
      clr_cnt_d  = clr_cnt_q;
      case (state_q)
         IDLE: begin
            addr_d    = '0;
            clr_cnt_d = '0;
            if (!(clear_req || scan_req)) begin
               d_in_d = sample_data;
               ena_d  = sample_valid;
            end
         end
         CLEAR: begin
            hist_clr_d = 1'b1;
            d_in_d     = addr_q;
            addr_d     = addr_q + 1'b1;
            clr_cnt_d  = clr_cnt_q + 1'b1;
         end
         SCAN: begin
            d_in_d  = addr_q;
            issue_d = 1'b1;
            addr_d  = addr_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         d_in_q     <= '0;
         ena_q      <= 1'b0;
         hist_clr_q <= 1'b0;
         issue_q    <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_bin_q[i] <= '0;
         end
      end else begin
         d_in_q        <= d_in_d;
         ena_q         <= ena_d;
         hist_clr_q    <= hist_clr_d;
         issue_q       <= issue_d;
         pipe_vld_q[0] <= issue_q;
         pipe_bin_q[0] <= d_in_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_bin_q[i] <= pipe_bin_q[i-1];
         end
      end
   end

   assign beat       = pipe_vld_q[RD_LAT-1];
   assign beat_bin   = pipe_bin_q[RD_LAT-1];
   assign scan_start = (state_q == IDLE) && (state_d == SCAN);

`ifdef HIST_SCAN_THRESH_EN
   logic [AW:0] above_q;

   assign pass = (mem_out >= thresh);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)          above_q <= '0;
      else if (scan_start) above_q <= '0;
      else if (out_valid)  above_q <= above_q + 1'b1;
   end

   assign above_cnt = above_q;
`else
   assign pass = 1'b1;
`endif

   assign d_in      = d_in_q;
   assign ena       = ena_q;
   assign hist_clr  = hist_clr_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign out_valid = beat && pass;
   assign out_bin   = out_valid ? beat_bin : '0;
   assign out_count = out_valid ? mem_out : '0;

   // Peak and total see every bin, independent of the threshold filter.
   hist_peak_tracker #(
      .AW   (AW),
      .SIZE (SIZE)
   ) u_peak (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .start       (scan_start),
      .valid       (beat),
      .bin         (beat_bin),
      .count       (mem_out),
      .peak_bin    (peak_bin),
      .peak_count  (peak_count),
      .total_count (total_count)
   );

endmodule

// File: tb/tb_histogram_scanner.sv
// Bench for histogram_scanner with a behavioural histogram_unit memory model.
module tb_histogram_scanner;

  localparam int AW     = 7;
  localparam int SIZE   = 7;
  localparam int RD_LAT = 2;
  localparam int NBINS  = 128;

  typedef struct packed {
    logic [AW-1:0]   bin;
    logic [SIZE-1:0] cnt;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0]      pb;
    logic [SIZE-1:0]    pc;
    logic [SIZE+AW-1:0] tot;
    logic [AW:0]        above;
  } sum_t;

  logic                 CLK;
  logic                 RST_N;
  logic                 sample_valid;
  logic [AW-1:0]        sample_data;
  logic                 clear_req;
  logic                 scan_req;
  logic [SIZE-1:0]      thresh;
  logic [AW:0]          above_cnt;
  logic [AW-1:0]        d_in;
  logic                 ena;
  logic                 hist_clr;
  logic [SIZE-1:0]      mem_out;
  logic                 busy;
  logic                 out_valid;
  logic [AW-1:0]        out_bin;
  logic [SIZE-1:0]      out_count;
  logic                 done;
  logic [AW-1:0]        peak_bin;
  logic [SIZE-1:0]      peak_count;
  logic [SIZE+AW-1:0]   total_count;

  int checks = 0;
  int errors = 0;
  int clr_cycles = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int ref_hist [NBINS];
  beat_t exp_q [$];
  sum_t  exp_sum_q [$];

  logic [SIZE-1:0] mem  [NBINS];
  logic [SIZE-1:0] rd_q [RD_LAT];

  histogram_scanner dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .clear_req    (clear_req),
    .scan_req     (scan_req),
`ifdef HIST_SCAN_THRESH_EN
    .thresh       (thresh),
    .above_cnt    (above_cnt),
`endif
    .d_in         (d_in),
    .ena          (ena),
    .hist_clr     (hist_clr),
    .mem_out      (mem_out),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_bin      (out_bin),
    .out_count    (out_count),
    .done         (done),
    .peak_bin     (peak_bin),
    .peak_count   (peak_count),
    .total_count  (total_count)
  );

`ifndef HIST_SCAN_THRESH_EN
  assign above_cnt = '0;
`endif

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- histogram_unit model ----------------
  always @(posedge CLK) begin
    if (hist_clr)  mem[d_in] <= '0;
    else if (ena)  mem[d_in] <= mem[d_in] + 1'b1;
    rd_q[0] <= mem[d_in];
    for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign mem_out = rd_q[RD_LAT-1];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    beat_t e;
    sum_t  s;
    if (hist_clr) clr_cycles++;
    if (out_valid) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got bin %0d count %0d, expected no beat", out_bin, out_count);
      end else begin
        e = exp_q.pop_front();
        check("beat_bin", 32'(out_bin), 32'(e.bin));
        check("beat_count", 32'(out_count), 32'(e.cnt));
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_sum_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        s = exp_sum_q.pop_front();
        check("peak_bin", 32'(peak_bin), 32'(s.pb));
        check("peak_count", 32'(peak_count), 32'(s.pc));
        check("total_count", 32'(total_count), 32'(s.tot));
`ifdef HIST_SCAN_THRESH_EN
        check("above_cnt", 32'(above_cnt), 32'(s.above));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d_in"},        32'(d_in), 0);
    check({tag, "_ena"},         32'(ena), 0);
    check({tag, "_hist_clr"},    32'(hist_clr), 0);
    check({tag, "_busy"},        32'(busy), 0);
    check({tag, "_out_valid"},   32'(out_valid), 0);
    check({tag, "_out_bin"},     32'(out_bin), 0);
    check({tag, "_out_count"},   32'(out_count), 0);
    check({tag, "_done"},        32'(done), 0);
    check({tag, "_peak_bin"},    32'(peak_bin), 0);
    check({tag, "_peak_count"},  32'(peak_count), 0);
    check({tag, "_total_count"}, 32'(total_count), 0);
  endtask

  task automatic add_sample(input int v, input int n);
    repeat (n) begin
      sample_valid = 1'b1;
      sample_data  = AW'(v);
      tick();
      ref_hist[v]++;
    end
    sample_valid = 1'b0;
  endtask

  // A scan_req raised alongside clear_req must be dropped.
  task automatic do_clear(input bit with_scan);
    int d0;
    d0 = done_cnt;
    clr_cycles = 0;
    clear_req = 1'b1;
    scan_req  = with_scan;
    tick();
    clear_req = 1'b0;
    scan_req  = 1'b0;
    for (int i = 0; i < 400 && busy; i++) tick();
    check("clear_end_busy", 32'(busy), 0);
    tick(3);
    check("clear_cycles", clr_cycles, 128);
    check("clear_stays_idle", 32'(busy), 0);
    check("clear_no_done", done_cnt, d0);
    for (int b = 0; b < NBINS; b++) ref_hist[b] = 0;
  endtask

  task automatic push_expected(input int pb, input int pc, input int tot);
    sum_t s;
    int above;
    above = 0;
    for (int b = 0; b < NBINS; b++) begin
      if (ref_hist[b] >= int'(thresh)) begin
        exp_q.push_back({AW'(b), SIZE'(ref_hist[b])});
        above++;
      end
    end
    s.pb    = AW'(pb);
    s.pc    = SIZE'(pc);
    s.tot   = (SIZE+AW)'(tot);
    s.above = (AW+1)'(above);
    exp_sum_q.push_back(s);
  endtask

  // Starts a scan; a sample in the request cycle must be dropped. poke re-requests mid-scan.
  task automatic do_scan(input int pb, input int pc, input int tot, input bit poke);
    int d0;
    d0 = done_cnt;
    push_expected(pb, pc, tot);
    scan_req     = 1'b1;
    sample_valid = 1'b1;
    sample_data  = AW'(9);
    tick();
    scan_req     = 1'b0;
    sample_valid = 1'b0;
    check("scan_busy", 32'(busy), 1);
    if (poke) begin
      tick(20);
      scan_req  = 1'b1;
      clear_req = 1'b1;
      tick();
      scan_req  = 1'b0;
      clear_req = 1'b0;
    end
    for (int i = 0; i < 600 && done_cnt == d0; i++) tick();
    check("scan_done_seen", done_cnt - d0, 1);
    tick(4);
    check("scan_beats_left", exp_q.size(), 0);
    check("scan_single_done", done_cnt - d0, 1);
    check("scan_idle", 32'(busy), 0);
    exp_q.delete();
    exp_sum_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    int d0;
    RST_N        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    clear_req    = 1'b0;
    scan_req     = 1'b0;
    thresh       = '0;
    for (int b = 0; b < NBINS; b++) begin
      mem[b]      = SIZE'($urandom_range(1, 100));
      ref_hist[b] = 0;
    end
    repeat (3) @(posedge CLK);
    #3;
    check_all_zero("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick(2);

    // Clear sweep then empty scan.
    do_clear(1'b0);
    do_scan(0, 0, 0, 1'b0);

    // Samples 5,5,5,9,9,127.
    add_sample(5, 3);
    add_sample(9, 2);
    add_sample(127, 1);
    tick(2);
    do_scan(5, 3, 6, 1'b0);
`ifdef HIST_SCAN_THRESH_EN
    thresh = SIZE'(2);
    do_scan(5, 3, 6, 1'b0);
    thresh = '0;
`endif

    // Tie between bins 40 and 3; ignored requests mid-scan.
    do_clear(1'b0);
    add_sample(40, 4);
    add_sample(3, 4);
    tick(2);
    do_scan(3, 4, 8, 1'b1);
    do_scan(3, 4, 8, 1'b0);

    // Clear and scan requested together: clear only.
    do_clear(1'b1);
    do_scan(0, 0, 0, 1'b0);

    // Reset mid-scan.
    add_sample(7, 2);
    tick(2);
    push_expected(7, 2, 2);
    d0 = done_cnt;
    b0 = beat_cnt;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    for (int i = 0; i < 300 && beat_cnt < b0 + 10; i++) tick();
    check("midscan_beats", beat_cnt - b0, 10);
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midscan");
    exp_q.delete();
    exp_sum_q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick(3);
    check("midscan_idle", 32'(busy), 0);
    check("midscan_no_done", done_cnt, d0);
    do_scan(7, 2, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
